// File: rtl/instr_result_checker.sv
// rtl/instr_result_checker.sv - walks an instruction register range, recomputes each result and tallies pass/fail
module instr_result_checker #(
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 4,
    parameter int OP_W   = 32,
    parameter int RES_W  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] read_pointer,
    input  logic [OPC_W-1:0]  iw_opc,
    input  logic [OP_W-1:0]   iw_op_a,
    input  logic [OP_W-1:0]   iw_op_b,
    input  logic [RES_W-1:0]  iw_result,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pass_count,
    output logic [ADDR_W:0]   fail_count,
    output logic              fail_seen,
    output logic [ADDR_W-1:0] first_fail_addr
);
    typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE_S} state_t;

    localparam logic [OPC_W-1:0]  OPC_ZERO  = OPC_W'(0);
    localparam logic [OPC_W-1:0]  OPC_PASSA = OPC_W'(1);
    localparam logic [OPC_W-1:0]  OPC_PASSB = OPC_W'(2);
    localparam logic [OPC_W-1:0]  OPC_ADD   = OPC_W'(3);
    localparam logic [OPC_W-1:0]  OPC_SUB   = OPC_W'(4);
    localparam logic [OPC_W-1:0]  OPC_MULT  = OPC_W'(5);
    localparam logic [OPC_W-1:0]  OPC_DIV   = OPC_W'(6);
    localparam logic [OPC_W-1:0]  OPC_MOD   = OPC_W'(7);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    state_t state, next_state;

    logic [ADDR_W-1:0] last_q;
    logic [OPC_W-1:0]  cap_opc;
    logic [OP_W-1:0]   cap_a;
    logic [OP_W-1:0]   cap_b;
    logic [RES_W-1:0]  cap_result;

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] expected;
    logic                    match;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && !abort) next_state = FETCH;
            FETCH:   next_state = abort ? IDLE : CHECK;
            CHECK:   if (abort)                      next_state = IDLE;
                     else if (read_pointer == last_q) next_state = DONE_S;
                     else                             next_state = FETCH;
            DONE_S:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == FETCH) || (state == CHECK);
        done = (state == DONE_S);
    end

    // Expected value depends only on the captured word, so the pointer may move freely.
    assign a_ext = {{(RES_W-OP_W){cap_a[OP_W-1]}}, cap_a};
    assign b_ext = {{(RES_W-OP_W){cap_b[OP_W-1]}}, cap_b};

    always_comb begin
        expected = '0;
        case (cap_opc)
            OPC_ZERO:  expected = '0;
            OPC_PASSA: expected = a_ext;
            OPC_PASSB: expected = b_ext;
            OPC_ADD:   expected = a_ext + b_ext;
            OPC_SUB:   expected = a_ext - b_ext;
            OPC_MULT:  expected = a_ext * b_ext;
            OPC_DIV:   if (b_ext != '0) expected = a_ext / b_ext;
            OPC_MOD:   if (b_ext != '0) expected = a_ext % b_ext;
            default:   expected = '0;
        endcase
    end

    assign match = ($unsigned(expected) == cap_result);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer    <= '0;
            last_q          <= '0;
            cap_opc         <= '0;
            cap_a           <= '0;
            cap_b           <= '0;
            cap_result      <= '0;
            pass_count      <= '0;
            fail_count      <= '0;
            fail_seen       <= 1'b0;
            first_fail_addr <= '0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    read_pointer    <= first_addr;
                    last_q          <= last_addr;
                    pass_count      <= '0;
                    fail_count      <= '0;
                    fail_seen       <= 1'b0;
                    first_fail_addr <= '0;
                end
                FETCH: if (!abort) begin
                    cap_opc    <= iw_opc;
                    cap_a      <= iw_op_a;
                    cap_b      <= iw_op_b;
                    cap_result <= iw_result;
                end
                CHECK: if (!abort) begin
                    if (match) begin
                        pass_count <= pass_count + CNT_ONE;
                    end else begin
                        fail_count <= fail_count + CNT_ONE;
                        if (!fail_seen) begin
                            fail_seen       <= 1'b1;
                            first_fail_addr <= read_pointer;
                        end
                    end
                    if (read_pointer != last_q) read_pointer <= read_pointer + PTR_ONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_result_checker.sv
// tb/tb_instr_result_checker.sv - randomized and directed check of instr_result_checker against a timeline model
module tb_instr_result_checker;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic [4:0]  read_pointer;
    logic [3:0]  iw_opc;
    logic [31:0] iw_op_a;
    logic [31:0] iw_op_b;
    logic [63:0] iw_result;
    logic        busy;
    logic        done;
    logic [5:0]  pass_count;
    logic [5:0]  fail_count;
    logic        fail_seen;
    logic [4:0]  first_fail_addr;

    logic [3:0] m_opc [32];
    int         m_a   [32];
    int         m_b   [32];
    longint     m_res [32];

    int e_busy [0:79];
    int e_done [0:79];
    int e_rp   [0:79];
    int e_pass [0:79];
    int e_fail [0:79];
    int e_fs   [0:79];
    int e_ffa  [0:79];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign iw_opc    = m_opc[read_pointer];
    assign iw_op_a   = m_a[read_pointer];
    assign iw_op_b   = m_b[read_pointer];
    assign iw_result = m_res[read_pointer];

    instr_result_checker dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr), .read_pointer(read_pointer),
        .iw_opc(iw_opc), .iw_op_a(iw_op_a), .iw_op_b(iw_op_b), .iw_result(iw_result),
        .busy(busy), .done(done), .pass_count(pass_count), .fail_count(fail_count),
        .fail_seen(fail_seen), .first_fail_addr(first_fail_addr)
    );

    function automatic longint model_result(input logic [3:0] opc, input int a, input int b);
        longint la = a;
        longint lb = b;
        case (opc)
            4'd1: return la;
            4'd2: return lb;
            4'd3: return la + lb;
            4'd4: return la - lb;
            4'd5: return la * lb;
            4'd6: return (b == 0) ? 64'sd0 : la / lb;
            4'd7: return (b == 0) ? 64'sd0 : la % lb;
            default: return 64'sd0;
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc > 0) begin
            chk("busy", busy, e_busy[cyc]);
            chk("done", done, e_done[cyc]);
            chk("read_pointer", read_pointer, e_rp[cyc]);
            chk("pass_count", pass_count, e_pass[cyc]);
            chk("fail_count", fail_count, e_fail[cyc]);
            chk("fail_seen", fail_seen, e_fs[cyc]);
            chk("first_fail_addr", first_fail_addr, e_ffa[cyc]);
        end
    end

    task automatic set_e(input int ad, input logic [3:0] opc, input int a, input int b, input longint res);
        m_opc[ad] = opc; m_a[ad] = a; m_b[ad] = b; m_res[ad] = res;
    endtask

    task automatic load_basic();
        set_e(0, 4'd3, 5, 3, 8);
        set_e(1, 4'd4, 5, 7, -2);
        set_e(2, 4'd5, -4, 6, -24);
        set_e(3, 4'd2, 1, 9, 9);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 32; i++) begin
            int a, b;
            longint r;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
            b = ($urandom_range(0, 5) == 0) ? 0 :
                (($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 40)) - 20);
            m_opc[i] = 4'($urandom_range(0, 15));
            m_a[i] = a;
            m_b[i] = b;
            r = model_result(m_opc[i], a, b);
            if ($urandom_range(0, 3) == 0) r = r ^ (64'sd1 << $urandom_range(0, 63));
            m_res[i] = r;
        end
    endtask

    // Cycle 0 is the start cycle; entry j is fetched in cycle 2j+1 and checked in 2j+2.
    task automatic run(input int first, input int last, input int abort_at);
        int n, len, c, ad, act_end;
        bit ok;
        int pp [0:32];
        int pf [0:32];
        int pa [0:32];
        n = ((last - first + 32) % 32) + 1;
        pp[0] = 0; pf[0] = 0; pa[0] = 0;
        for (int j = 0; j < n; j++) begin
            ad = (first + j) % 32;
            ok = (m_res[ad] == model_result(m_opc[ad], m_a[ad], m_b[ad]));
            pp[j+1] = pp[j] + (ok ? 1 : 0);
            pf[j+1] = pf[j] + (ok ? 0 : 1);
            pa[j+1] = (pf[j] == 0 && !ok) ? ad : pa[j];
        end
        len = (abort_at < 0) ? 2*n + 4 : 2*abort_at + 5;
        act_end = (abort_at < 0) ? 2*n : 2*abort_at + 2;
        for (int k = 1; k < len; k++) begin
            if (k <= act_end) begin
                e_busy[k] = 1; e_done[k] = 0; e_rp[k] = (first + (k-1)/2) % 32; c = (k-1)/2;
            end else if (abort_at < 0 && k == 2*n + 1) begin
                e_busy[k] = 0; e_done[k] = 1; e_rp[k] = last; c = n;
            end else begin
                e_busy[k] = 0; e_done[k] = 0;
                e_rp[k] = (abort_at < 0) ? last : (first + abort_at) % 32;
                c = (abort_at < 0) ? n : abort_at;
            end
            e_pass[k] = pp[c]; e_fail[k] = pf[c]; e_fs[k] = (pf[c] > 0) ? 1 : 0; e_ffa[k] = pa[c];
        end
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            cyc = k;
            chk_en = 1'b1;
            start = (k == 0) || (k == 3 && (abort_at < 0 || 3 <= act_end)) ||
                    (abort_at < 0 && k == 2*n + 1);
            first_addr = (k == 0) ? 5'(first) : ~5'(first);
            last_addr  = (k == 0) ? 5'(last)  : ~5'(last);
            abort = (abort_at >= 0 && k == 2*abort_at + 2);
        end
        @(posedge clk); #1;
        chk_en = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rp"}, read_pointer, 0);
        chk({tag, "_pass"}, pass_count, 0);
        chk({tag, "_fail"}, fail_count, 0);
        chk({tag, "_fs"}, fail_seen, 0);
        chk({tag, "_ffa"}, first_fail_addr, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) set_e(i, 4'd0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        reset_n = 1'b1;

        chk("pin_add", model_result(4'd3, 5, 3), 8);
        chk("pin_sub", model_result(4'd4, 5, 7), -2);
        chk("pin_mult", model_result(4'd5, -4, 6), -24);
        chk("pin_div0", model_result(4'd6, 7, 0), 0);
        chk("pin_mod", model_result(4'd7, -7, 2), -1);
        chk("pin_div", model_result(4'd6, -7, 2), -3);
        chk("pin_opc9", model_result(4'd9, 3, 4), 0);
        chk("pin_divmin", model_result(4'd6, 32'sh8000_0000, -1), 64'sd2147483648);

        load_basic();
        run(0, 3, -1);
        chk("t1_pass", pass_count, 4);
        chk("t1_fail", fail_count, 0);
        chk("t1_done_at", e_done[9], 1);

        set_e(2, 4'd5, 3, 4, 0);
        run(0, 3, -1);
        chk("t2_fail", fail_count, 1);
        chk("t2_pass", pass_count, 3);
        chk("t2_ffa", first_fail_addr, 2);
        set_e(3, 4'd2, 1, 9, 10);
        run(0, 3, -1);
        chk("t2b_fail", fail_count, 2);
        chk("t2b_ffa", first_fail_addr, 2);

        set_e(0, 4'd6, 7, 0, 0);
        set_e(1, 4'd7, -7, 2, -1);
        set_e(2, 4'd6, -7, 2, -3);
        set_e(3, 4'd6, 32'sh8000_0000, -1, 64'sd2147483648);
        run(0, 3, -1);
        chk("t4_pass", pass_count, 4);
        chk("t4_fs", fail_seen, 0);

        load_basic();
        for (int i = 4; i < 8; i++) set_e(i, 4'd3, i, 1, i + 1);
        run(0, 7, 2);
        chk("t5_pass", pass_count, 2);
        chk("t5_busy", busy, 0);

        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk) chk("start_abort_idle", busy, 0);

        randomize_mem();
        run(30, 1, -1);
        chk("t3_total", pass_count + fail_count, 4);
        run(0, 31, -1);
        chk("full_total", pass_count + fail_count, 32);
        run(17, 17, -1);

        @(posedge clk); #1 first_addr = 5'd3; last_addr = 5'd12; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk_all_zero("midrun_reset");
        @(posedge clk); #1 reset_n = 1'b1;
        run(3, 12, -1);

        for (int t = 0; t < 8; t++) begin
            randomize_mem();
            run(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                ($urandom_range(0, 3) == 0) ? 0 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
